// File: rtl/rv32_dmem_responder.sv
// rtl/rv32_dmem_responder.sv - RV32I data-memory responder with wait states and byte-masked stores.
// Optional misaligned-access error reporting is enabled by defining DMEM_ALIGN_CHECK_EN.
module rv32_dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [2:0]      cnt, cnt_nxt;
    logic            we_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            cur_we;
    logic [AW+1:0]   cur_addr;
    logic [31:0]     cur_wdata;
    logic [3:0]      cur_be;
    logic [AW-1:0]   cur_idx;
    logic            misaligned;
    logic            accept;
    logic            commit;
    logic            unused_bits;

    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;
    assign unused_bits = ^{req_addr[31:AW+2], req_addr[1:0], addr_q[1:0]};

    // With zero latency the commit edge is also the accept edge, so use live request fields.
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_be    = be_q;
        if (state == IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr[AW+1:0];
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end
    end

    assign cur_idx = cur_addr[AW+1:2];
`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = (cur_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 3'(LATENCY);
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 3'd1;
                if (cnt == 3'd1) state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign commit = (state != RESP) && (state_nxt == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (commit) begin
                rsp_err   <= misaligned;
                rsp_rdata <= (misaligned || cur_we) ? 32'd0 : mem[cur_idx];
            end
        end
    end

    // Memory has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (commit && cur_we && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_rv32_dmem_responder.sv
// tb/tb_rv32_dmem_responder.sv - directed self-checking bench for rv32_dmem_responder.
module tb_rv32_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instance 0: LATENCY=1, instance 1: LATENCY=0, instance 2: LATENCY=7
    for (genvar g = 0; g < 3; g++) begin : g_dut
        rv32_dmem_responder #(
            .DEPTH_WORDS(256),
            .LATENCY(g == 0 ? 1 : (g == 1 ? 0 : 7))
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_we(req_we[g]),
            .req_addr(req_addr[g]),
            .req_wdata(req_wdata[g]),
            .req_be(req_be[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err(rsp_err[g])
        );
    end

    task automatic start_req(input int k, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
        int n;
        n = 0;
        req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wdata; req_be[k] = be;
        req_valid[k] = 1'b1;
        while (!req_ready[k] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL accept_timeout dut=%0d waited=%0d limit=50", k, n);
        end
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
    endtask

    task automatic wait_rsp(input int k, output int lat);
        lat = 1;
        while (!rsp_valid[k] && lat < 60) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic xact(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] data, output logic err, output int lat);
        rsp_ready[k] = 1'b1;
        start_req(k, we, addr, wdata, be);
        wait_rsp(k, lat);
        data = rsp_rdata[k];
        err  = rsp_err[k];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e; int lat;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'd0 || rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b d=%h e=%b rdy=%b want 0 0 0 0",
                     rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0]);
        end
        rst = 1'b0; #1;
        checks++;
        if (req_ready[0] !== 1'b1) begin
            failures++; $display("FAIL ready_after_reset got %b want 1", req_ready[0]);
        end
        // Reset while a load response is pending
        xact(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, d, e, lat);
        rsp_ready[1] = 1'b0;
        start_req(1, 1'b0, 32'h40, 32'h0, 4'h0);
        wait_rsp(1, lat);
        checks++;
        if (rsp_rdata[1] !== 32'hCAFEF00D) begin
            failures++; $display("FAIL pre_reset_load got %h want cafef00d", rsp_rdata[1]);
        end
        rst = 1'b1; #1;
        checks++;
        if (rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'd0) begin
            failures++; $display("FAIL reset_in_resp got v=%b d=%h want 0 0", rsp_valid[1], rsp_rdata[1]);
        end
        @(posedge clk); #1; rst = 1'b0; #1;
        checks++;
        if (req_ready[1] !== 1'b1) begin
            failures++; $display("FAIL ready_after_resp_reset got %b want 1", req_ready[1]);
        end
        // Store committed, then reset in RESP: the write must persist
        rsp_ready[1] = 1'b0;
        start_req(1, 1'b1, 32'h44, 32'h13579BDF, 4'hF);
        wait_rsp(1, lat);
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        xact(1, 1'b0, 32'h40, 32'h0, 4'h0, d, e, lat);
        checks++;
        if (d !== 32'hCAFEF00D) begin
            failures++; $display("FAIL mem_after_reset got %h want cafef00d", d);
        end
        xact(1, 1'b0, 32'h44, 32'h0, 4'h0, d, e, lat);
        checks++;
        if (d !== 32'h13579BDF) begin
            failures++; $display("FAIL committed_store_kept got %h want 13579bdf", d);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] d; logic e; int lat;
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, d, e, lat);
        checks++;
        if (lat !== 2 || d !== 32'd0 || e !== 1'b0) begin
            failures++; $display("FAIL store_rsp got lat=%0d d=%h e=%b want 2 0 0", lat, d, e);
        end
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, d, e, lat);
        checks++;
        if (lat !== 2 || d !== 32'hDEADBEEF || e !== 1'b0) begin
            failures++; $display("FAIL load_rsp got lat=%0d d=%h e=%b want 2 deadbeef 0", lat, d, e);
        end
    endtask

    task automatic test_byte_enables();
        logic [31:0] d; logic e; int lat;
        xact(0, 1'b1, 32'h20, 32'h11223344, 4'hF, d, e, lat);
        xact(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, d, e, lat);
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, d, e, lat);
        checks++;
        if (d !== 32'h11BB33DD) begin
            failures++; $display("FAIL byte_enable got %h want 11bb33dd", d);
        end
        xact(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, d, e, lat);
        checks++;
        if (lat !== 2 || d !== 32'd0) begin
            failures++; $display("FAIL be0_rsp got lat=%0d d=%h want 2 0", lat, d);
        end
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, d, e, lat);
        checks++;
        if (d !== 32'h11BB33DD) begin
            failures++; $display("FAIL be0_noop got %h want 11bb33dd", d);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic e; int lat;
        xact(1, 1'b1, 32'h30, 32'h12345678, 4'hF, d, e, lat);
        checks++;
        if (lat !== 1) begin
            failures++; $display("FAIL lat0_store got lat=%0d want 1", lat);
        end
        rsp_ready[1] = 1'b0;
        start_req(1, 1'b0, 32'h30, 32'h0, 4'h0);
        wait_rsp(1, lat);
        checks++;
        if (lat !== 1) begin
            failures++; $display("FAIL lat0_load got lat=%0d want 1", lat);
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'h12345678 || req_ready[1] !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d got v=%b d=%h rdy=%b want 1 12345678 0",
                         c, rsp_valid[1], rsp_rdata[1], req_ready[1]);
            end
            @(posedge clk); #1;
        end
        rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
            failures++; $display("FAIL after_handshake got v=%b rdy=%b want 0 1", rsp_valid[1], req_ready[1]);
        end
        xact(2, 1'b1, 32'h50, 32'hA5A5F00F, 4'hF, d, e, lat);
        checks++;
        if (lat !== 8) begin
            failures++; $display("FAIL lat7_store got lat=%0d want 8", lat);
        end
        xact(2, 1'b0, 32'h50, 32'h0, 4'h0, d, e, lat);
        checks++;
        if (lat !== 8 || d !== 32'hA5A5F00F) begin
            failures++; $display("FAIL lat7_load got lat=%0d d=%h want 8 a5a5f00f", lat, d);
        end
    endtask

    task automatic test_wrap_abort();
        logic [31:0] d; logic e; int lat;
        xact(0, 1'b1, 32'h400, 32'h0BADF00D, 4'hF, d, e, lat);
        xact(0, 1'b0, 32'h000, 32'h0, 4'h0, d, e, lat);
        checks++;
        if (d !== 32'h0BADF00D) begin
            failures++; $display("FAIL wrap got %h want 0badf00d", d);
        end
        xact(2, 1'b1, 32'h60, 32'h55AA55AA, 4'hF, d, e, lat);
        start_req(2, 1'b1, 32'h60, 32'hFFFFFFFF, 4'hF);
        @(posedge clk); #1;
        rst = 1'b1; #1;
        checks++;
        if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b0) begin
            failures++; $display("FAIL abort_outputs got v=%b rdy=%b want 0 0", rsp_valid[2], req_ready[2]);
        end
        @(posedge clk); #1; rst = 1'b0;
        xact(2, 1'b0, 32'h60, 32'h0, 4'h0, d, e, lat);
        checks++;
        if (d !== 32'h55AA55AA) begin
            failures++; $display("FAIL abort_store got %h want 55aa55aa", d);
        end
    endtask

    task automatic test_align();
        logic [31:0] d; logic e; int lat;
        logic [31:0] exp_store_d, exp_mem, exp_load_d;
        logic        exp_err;
`ifdef DMEM_ALIGN_CHECK_EN
        exp_err = 1'b1; exp_store_d = 32'd0; exp_mem = 32'h22222222; exp_load_d = 32'd0;
`else
        exp_err = 1'b0; exp_store_d = 32'd0; exp_mem = 32'h99999999; exp_load_d = 32'h99999999;
`endif
        xact(0, 1'b1, 32'h10, 32'h22222222, 4'hF, d, e, lat);
        checks++;
        if (e !== 1'b0) begin
            failures++; $display("FAIL aligned_err got %b want 0", e);
        end
        xact(0, 1'b1, 32'h13, 32'h99999999, 4'hF, d, e, lat);
        checks++;
        if (e !== exp_err || d !== exp_store_d || lat !== 2) begin
            failures++; $display("FAIL misaligned_store got e=%b d=%h lat=%0d want %b %h 2", e, d, lat, exp_err, exp_store_d);
        end
        xact(0, 1'b0, 32'h11, 32'h0, 4'h0, d, e, lat);
        checks++;
        if (e !== exp_err || d !== exp_load_d) begin
            failures++; $display("FAIL misaligned_load got e=%b d=%h want %b %h", e, d, exp_err, exp_load_d);
        end
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, d, e, lat);
        checks++;
        if (d !== exp_mem || e !== 1'b0) begin
            failures++; $display("FAIL align_mem got d=%h e=%b want %h 0", d, e, exp_mem);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic e; int lat;
        xact(0, 1'b1, 32'h70, 32'h01020304, 4'hF, d, e, lat);
        checks++;
        if (req_ready[0] !== 1'b1) begin
            failures++; $display("FAIL b2b_ready got %b want 1", req_ready[0]);
        end
        xact(0, 1'b0, 32'h70, 32'h0, 4'h0, d, e, lat);
        checks++;
        if (d !== 32'h01020304 || lat !== 2) begin
            failures++; $display("FAIL b2b_load got d=%h lat=%0d want 01020304 2", d, lat);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 32'd0;
            req_wdata[i] = 32'd0; req_be[i] = 4'd0; rsp_ready[i] = 1'b1;
        end
        test_reset();
        test_store_load();
        test_byte_enables();
        test_backpressure();
        test_wrap_abort();
        test_align();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
